// File: rtl/clkdiv_seq_if.sv
// clkdiv_seq_if
//   Control/status bundle between the control-register block (master) and the
//   CLKDIV sequencer (slave).
//   en          : divider enable; 0 stops the divider and holds it in reset
//   restart_req : re-sequence request, level-sampled
//   div_resetn  : CLKDIV RESETN drive (registered)
//   ready       : divided clock stable and usable (registered)
//   busy        : sequence in progress
//   phase       : hclkin count within the current divided period
//   div_stb     : one-cycle strobe per divided period
interface clkdiv_seq_if #(
    parameter int DIV = 4
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          en;
    logic          restart_req;
    logic          div_resetn;
    logic          ready;
    logic          busy;
    logic [PW-1:0] phase;
    logic          div_stb;

    modport master (
        output en, restart_req,
        input  div_resetn, ready, busy, phase, div_stb
    );

    modport slave (
        input  en, restart_req,
        output div_resetn, ready, busy, phase, div_stb
    );
endinterface

// File: rtl/clkdiv_seq.sv
// clkdiv_seq
//   Sequencer for the CLKDIV hard divider. Holds the divider in reset for
//   HOLD_CYCLES, releases it, waits SETTLE_CYCLES before flagging ready, and
//   tracks the divider phase to give a strobe aligned to each divided period.
//   hclkin : fast clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : clkdiv_seq_if.slave (en, restart_req in; div_resetn, ready,
//            busy, phase, div_stb out)
module clkdiv_seq #(
    parameter int DIV           = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic          hclkin,
    input  logic          resetn,
    clkdiv_seq_if.slave   bus
);
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CMAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST     = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_div_resetn, w_div_resetn_nxt;
    logic          r_ready, w_ready_nxt;
    logic [PW-1:0] r_phase, w_phase_nxt;

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_div_resetn <= 1'b0;
            r_ready      <= 1'b0;
            r_phase      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div_resetn <= w_div_resetn_nxt;
            r_ready      <= w_ready_nxt;
            r_phase      <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_div_resetn_nxt = r_div_resetn;
        w_ready_nxt      = r_ready;
        w_phase_nxt      = '0;

        case (r_state)
            S_HOLD: begin
                w_div_resetn_nxt = 1'b0;
                w_ready_nxt      = 1'b0;
                // Clearing while disabled guarantees a full hold after re-enable.
                if (!bus.en) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt        = '0;
                    w_div_resetn_nxt = 1'b1;
                    w_state_nxt      = S_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                // restart_req is deliberately not looked at here.
                if (!bus.en) begin
                    w_cnt_nxt        = '0;
                    w_div_resetn_nxt = 1'b0;
                    w_ready_nxt      = 1'b0;
                    w_state_nxt      = S_HOLD;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (!bus.en || bus.restart_req) begin
                    w_cnt_nxt        = '0;
                    w_div_resetn_nxt = 1'b0;
                    w_ready_nxt      = 1'b0;
                    w_state_nxt      = S_HOLD;
                end
            end
            default: begin
                w_cnt_nxt        = '0;
                w_div_resetn_nxt = 1'b0;
                w_ready_nxt      = 1'b0;
                w_state_nxt      = S_HOLD;
            end
        endcase

        // Phase counts only while the divider is out of reset on both sides of
        // the edge: it sits at 0 on the release edge and clears when the
        // divider is put back into reset.
        if (r_div_resetn && w_div_resetn_nxt) begin
            w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // Decodes of registered state only: no path from en/restart_req.
    assign bus.div_resetn = r_div_resetn;
    assign bus.ready      = r_ready;
    assign bus.busy       = (r_state != S_RUN);
    assign bus.phase      = r_phase;
    assign bus.div_stb    = r_ready && (r_phase == PH_LAST);

endmodule

// File: tb/tb_clkdiv_seq.sv
module tb_clkdiv_seq;
    logic hclkin = 1'b0;
    logic resetn = 1'b0;
    logic en     = 1'b0;
    logic rr     = 1'b0;

    always #5 hclkin = ~hclkin;

    clkdiv_seq_if #(.DIV(4)) b0();
    clkdiv_seq_if #(.DIV(2)) b1();

    assign b0.en          = en;
    assign b0.restart_req = rr;
    assign b1.en          = en;
    assign b1.restart_req = rr;

    clkdiv_seq #(.DIV(4), .HOLD_CYCLES(16), .SETTLE_CYCLES(8)) u0 (
        .hclkin(hclkin), .resetn(resetn), .bus(b0.slave)
    );
    clkdiv_seq #(.DIV(2), .HOLD_CYCLES(2), .SETTLE_CYCLES(1)) u1 (
        .hclkin(hclkin), .resetn(resetn), .bus(b1.slave)
    );

    int n_err = 0;
    int n_chk = 0;
    int ecnt  = 0;   // edges since reset release
    int age0  = 0;   // edges since the current sequence began (default DUT)
    int age1  = 0;   // same, for the small-parameter DUT

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    // A sequence is a count of usable edges since it (re)started; every output
    // follows from that count alone.
    task automatic model_step(inout int age, input int h, input int s);
        if (!en)                       age = 0;
        else if (rr && age >= h + s)   age = 0;
        else                           age = age + 1;
    endtask

    task automatic cmp(input string nm, input int age, input int h, input int s, input int d,
                       input logic dr, input logic rdy, input logic bsy, input int ph,
                       input logic stb);
        int edr, erdy, eph, estb;
        edr  = (age >= h) ? 1 : 0;
        erdy = (age >= h + s) ? 1 : 0;
        eph  = edr ? (age - h) % d : 0;
        estb = (erdy && eph == d - 1) ? 1 : 0;
        chk({nm, ".div_resetn"}, int'(dr), edr);
        chk({nm, ".ready"}, int'(rdy), erdy);
        chk({nm, ".busy"}, int'(bsy), 1 - erdy);
        chk({nm, ".phase"}, ph, eph);
        chk({nm, ".div_stb"}, int'(stb), estb);
    endtask

    task automatic tick();
        @(posedge hclkin);
        if (!resetn) begin
            age0 = 0; age1 = 0; ecnt = 0;
        end else begin
            model_step(age0, 16, 8);
            model_step(age1, 2, 1);
            ecnt++;
        end
        #1;
        cmp("d0", age0, 16, 8, 4, b0.div_resetn, b0.ready, b0.busy, int'(b0.phase), b0.div_stb);
        cmp("d1", age1, 2, 1, 2, b1.div_resetn, b1.ready, b1.busy, int'(b1.phase), b1.div_stb);
        @(negedge hclkin);
    endtask

    task automatic run_to(input int e);
        int g = 0;
        while (ecnt < e && g < 5000) begin
            tick();
            g++;
        end
        if (ecnt < e) chk("run_to_bound", ecnt, e);
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, ".rst.d0.div_resetn"}, int'(b0.div_resetn), 0);
        chk({nm, ".rst.d0.ready"}, int'(b0.ready), 0);
        chk({nm, ".rst.d0.busy"}, int'(b0.busy), 1);
        chk({nm, ".rst.d0.phase"}, int'(b0.phase), 0);
        chk({nm, ".rst.d0.div_stb"}, int'(b0.div_stb), 0);
        chk({nm, ".rst.d1.div_resetn"}, int'(b1.div_resetn), 0);
        chk({nm, ".rst.d1.ready"}, int'(b1.ready), 0);
        chk({nm, ".rst.d1.busy"}, int'(b1.busy), 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0; en = 1'b1; rr = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up, default and small-parameter DUTs side by side, then restart.
        @(negedge hclkin);
        do_reset();
        chk_rst("powerup");
        for (int e = 1; e <= 64; e++) begin
            run_to(e);
            if (e == 1)  chk("sw.dr@1", int'(b1.div_resetn), 0);
            if (e == 2)  chk("sw.dr@2", int'(b1.div_resetn), 1);
            if (e == 2)  chk("sw.ready@2", int'(b1.ready), 0);
            if (e == 3)  chk("sw.ready@3", int'(b1.ready), 1);
            if (e >= 3 && e <= 8) chk("sw.stb", int'(b1.div_stb), (e % 2 == 1) ? 1 : 0);
            if (e == 15) chk("pu.dr@15", int'(b0.div_resetn), 0);
            if (e == 16) chk("pu.dr@16", int'(b0.div_resetn), 1);
            if (e == 23) chk("pu.ready@23", int'(b0.ready), 0);
            if (e == 24) chk("pu.ready@24", int'(b0.ready), 1);
            if (e == 24) chk("pu.phase@24", int'(b0.phase), 0);
            if (e >= 24 && e <= 38)
                chk("pu.stb", int'(b0.div_stb), (e == 27 || e == 31 || e == 35) ? 1 : 0);
            if (e == 39) rr = 1'b1;
            if (e == 40) begin
                rr = 1'b0;
                chk("rs.ready@40", int'(b0.ready), 0);
                chk("rs.dr@40", int'(b0.div_resetn), 0);
                chk("rs.phase@40", int'(b0.phase), 0);
            end
            if (e == 55) chk("rs.dr@55", int'(b0.div_resetn), 0);
            if (e == 56) chk("rs.dr@56", int'(b0.div_resetn), 1);
            if (e == 63) chk("rs.ready@63", int'(b0.ready), 0);
            if (e == 64) chk("rs.ready@64", int'(b0.ready), 1);
        end

        // Restart request during HOLD/SETTLE is ignored.
        do_reset();
        run_to(4);  rr = 1'b1;
        run_to(16); chk("ig.dr@16", int'(b0.div_resetn), 1);
        run_to(20); rr = 1'b0;
        run_to(24); chk("ig.ready@24", int'(b0.ready), 1);

        // Enable gating mid-HOLD, then stop in RUN.
        do_reset();
        run_to(9);  en = 1'b0;
        run_to(19); en = 1'b1;
        run_to(34); chk("en.dr@34", int'(b0.div_resetn), 0);
        run_to(35); chk("en.dr@35", int'(b0.div_resetn), 1);
        run_to(42); chk("en.ready@42", int'(b0.ready), 0);
        run_to(43); chk("en.ready@43", int'(b0.ready), 1);
        run_to(50); en = 1'b0; rr = 1'b1;
        run_to(51); rr = 1'b0;
        chk("en.ready@51", int'(b0.ready), 0);
        chk("en.dr@51", int'(b0.div_resetn), 0);
        run_to(60);
        chk("en.busy@60", int'(b0.busy), 1);
        chk("en.dr@60", int'(b0.div_resetn), 0);
        en = 1'b1;
        run_to(75); chk("en.dr@75", int'(b0.div_resetn), 0);
        run_to(76); chk("en.dr@76", int'(b0.div_resetn), 1);

        // Asynchronous reset mid-SETTLE, no clock edge needed.
        do_reset();
        run_to(19);
        chk("ar.dr@19", int'(b0.div_resetn), 1);
        #2 resetn = 1'b0;
        #1 chk_rst("async");
        tick(); tick();
        resetn = 1'b1;
        run_to(15); chk("ar.dr@15", int'(b0.div_resetn), 0);
        run_to(16); chk("ar.dr@16", int'(b0.div_resetn), 1);
        run_to(24); chk("ar.ready@24", int'(b0.ready), 1);

        // Randomized enable/restart/reset traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (en) begin
                if ($urandom_range(0, 79) == 0) en = 1'b0;
            end else begin
                if ($urandom_range(0, 5) == 0) en = 1'b1;
            end
            rr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 resetn = 1'b0;
                #1 chk_rst("rnd");
                tick();
                resetn = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/clkdiv_seq.md
# clkdiv_seq

Sequencer for the Gowin CLKDIV hard divider used by the system clock tree. It runs on the fast clock (`hclkin`) and owns the divider's RESETN pin. It holds the divider in reset after system reset, releases it, and waits a settle interval before declaring the divided clock usable. It also tracks the divider phase so fast-domain logic gets a one-cycle strobe aligned to each divided period, and it supports run-time stop/restart requests from the control-register block.

## Interface

Parameters:
- `DIV`, default 4: divide ratio programmed into the CLKDIV instance; integer 2..8.
- `HOLD_CYCLES`, default 16: `hclkin` cycles the divider is held in reset per sequence; at least 2.
- `SETTLE_CYCLES`, default 8: `hclkin` cycles from divider reset release to `ready`; at least 1.

Ports:
- `hclkin` input 1: fast clock; all logic runs on its rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `en` input 1: divider enable; 0 stops the divider and holds it in reset.
- `restart_req` input 1: re-sequence request, level-sampled, honoured only in RUN.
- `div_resetn` output 1: drives CLKDIV RESETN; registered.
- `ready` output 1: divided clock is stable and usable; registered.
- `busy` output 1: sequence in progress (state is not RUN).
- `phase` output clog2(DIV): `hclkin` count within the current divided period.
- `div_stb` output 1: one `hclkin` cycle per divided period, when `phase == DIV-1` and `ready` is 1.

## Operation

States:
- HOLD: `div_resetn`=0, `ready`=0.
  - `cnt` increments each edge while `en`=1.
  - `cnt` clears to 0 while `en`=0, so a full hold is always served after re-enable.
  - When `cnt == HOLD_CYCLES-1` and `en`=1: `cnt` clears, `div_resetn` is set to 1, next state is SETTLE.
- SETTLE: `div_resetn`=1, `ready`=0, `cnt` increments.
  - When `cnt == SETTLE_CYCLES-1`: `cnt` clears, `ready` is set to 1, next state is RUN.
  - `en`=0 sends the block to HOLD.
- RUN: `div_resetn`=1, `ready`=1.
  - `en`=0 or `restart_req`=1 sends the block to HOLD.
  - On that edge: `div_resetn` goes 0, `ready` goes 0, `cnt` and `phase` clear.

Phase tracking:
- `phase` is held at 0 while `div_resetn`=0.
- From the first cycle with `div_resetn`=1, `phase` increments by 1 per edge and wraps from DIV-1 to 0.

Decode and width rules:
- `div_stb` and `busy` are pure decodes of registered state. They must be glitch-free and carry no input-to-output combinational path.
- `cnt` width is clog2(max(HOLD_CYCLES, SETTLE_CYCLES)); it never exceeds its terminal value.

Boundary behaviour:
- `restart_req` in HOLD or SETTLE is ignored and not remembered.
- `restart_req` and `en`=0 together in RUN: go to HOLD, and remain there until `en`=1.
- `resetn` low at any time, including mid-sequence, asynchronously forces the reset values below.

Reset values: state HOLD, `cnt`=0, `div_resetn`=0, `ready`=0, `busy`=1, `phase`=0, `div_stb`=0.

## Timing

Edge 1 is the first rising edge of `hclkin` with `resetn` high and `en`=1. Defaults apply.
- `div_resetn` is low through edge 16 and goes high after edge HOLD_CYCLES (16).
  - This gives exactly HOLD_CYCLES full cycles of divider reset.
- After edge 16+k, `phase` = k mod DIV.
- `ready` and `busy`=0 are valid after edge HOLD_CYCLES+SETTLE_CYCLES (24); `phase` is 0 at that point.
- `div_stb` first goes high after edge 27 and repeats every DIV cycles.
- Restart latency: with `restart_req` sampled at edge t, `ready` is 0 after t.
  - `div_resetn` is 0 after t and high again after t+HOLD_CYCLES.
  - `ready` returns after t+HOLD_CYCLES+SETTLE_CYCLES.
- Stop latency: with `en`=0 sampled at edge t, `div_resetn` and `ready` are 0 after t.

## Test plan

- Power-up: release `resetn` with `en`=1.
  - `div_resetn` rises after edge 16 and `ready` rises after edge 24.
  - `div_stb` is high only in the cycles after edges 27, 31 and 35.
- Restart in RUN: pulse `restart_req` for one cycle at edge 40.
  - `ready` and `div_resetn` drop after edge 40 and `phase` is 0.
  - `div_resetn` rises after edge 56 and `ready` after edge 64.
- Ignored request: hold `restart_req`=1 during edges 5..20.
  - The sequence is unchanged: `ready` is high after edge 24 and no extra hold occurs.
- Enable gating: take `en`=0 at edge 10, mid-HOLD, and restore it at edge 20.
  - `div_resetn` rises after edge 35 and `ready` after edge 43.
  - Then take `en`=0 in RUN; `ready` drops the next edge and the block stays in HOLD while `en`=0.
- Async reset mid-SETTLE: assert `resetn`=0 between edges 19 and 20.
  - All outputs take reset values immediately, with no clock.
  - After release, the full 16/24-cycle sequence repeats.
- Parameter sweep: DIV=2, HOLD_CYCLES=2, SETTLE_CYCLES=1.
  - `div_resetn` rises after edge 2 and `ready` after edge 3.
  - `div_stb` is high in the cycles after edges 3, 5 and 7.
